// File: rtl/mcast_id_seq_gen_if.sv
`default_nettype none
// mcast_id_seq_gen_if: tag stream from the multicast ID generator to the PE-array config loader.
// Rev 1.0
interface mcast_id_seq_gen_if #(
  parameter int ARR_H = 6,
  parameter int ARR_W = 8,
  parameter int XID_W = 5,
  parameter int YID_W = 3
);
  localparam int ROW_W = (ARR_H > 1) ? $clog2(ARR_H) : 1;
  localparam int COL_W = (ARR_W > 1) ? $clog2(ARR_W) : 1;

  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic [XID_W-1:0] filter_xid, ifmap_xid, ipsum_xid, opsum_xid;
  logic [YID_W-1:0] filter_yid, ifmap_yid, ipsum_yid, opsum_yid;
  logic             out_last;

  modport master (
    output out_valid, out_row, out_col,
    output filter_xid, ifmap_xid, ipsum_xid, opsum_xid,
    output filter_yid, ifmap_yid, ipsum_yid, opsum_yid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_row, out_col,
    input  filter_xid, ifmap_xid, ipsum_xid, opsum_xid,
    input  filter_yid, ifmap_yid, ipsum_yid, opsum_yid,
    input  out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/mcast_id_seq_gen.sv
`default_nettype none
// mcast_id_seq_gen: streams filter/ifmap/ipsum/opsum X/Y multicast tags, one PE per transfer.
// Rev 1.0
module mcast_id_seq_gen #(
  parameter int ARR_H = 6,
  parameter int ARR_W = 8,
  parameter int XID_W = 5,
  parameter int YID_W = 3
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        start,
  input  wire logic                        abort,
  input  wire logic                        cfg_linear,
  input  wire logic [$clog2(ARR_H+1)-1:0]  cfg_kh,
  input  wire logic [$clog2(ARR_W+1)-1:0]  cfg_e,
  input  wire logic [$clog2(ARR_W+1)-1:0]  cfg_t,
  mcast_id_seq_gen_if.master               out_if,
  output logic                             busy,
  output logic                             done,
  output logic                             cfg_err
);
  localparam int ROW_W = (ARR_H > 1) ? $clog2(ARR_H) : 1;
  localparam int COL_W = (ARR_W > 1) ? $clog2(ARR_W) : 1;
  localparam int KH_W  = $clog2(ARR_H+1);
  localparam int E_W   = $clog2(ARR_W+1);
  localparam int FX_W  = $clog2(ARR_H*ARR_W+1);
  localparam logic [31:0]      H_U      = ARR_H;
  localparam logic [31:0]      W_U      = ARR_W;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARR_H-1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(ARR_W-1);

  typedef enum logic [0:0] {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             linear_q, linear_d;
  logic [KH_W-1:0]  kh_q, kh_d;
  logic [E_W-1:0]   e_q, e_d, t_q, t_d;
  logic [ROW_W-1:0] row_q, row_d, k_q, k_d, s_q, s_d;
  logic [COL_W-1:0] col_q, col_d, jm_q, jm_d;
  logic [FX_W-1:0]  fx_q, fx_d;
  logic             valid_q, valid_d, last_q, last_d;
  logic             busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic [XID_W-1:0] fxid_q, fxid_d, ixid_q, ixid_d, pxid_q, pxid_d, oxid_q, oxid_d;
  logic [YID_W-1:0] fyid_q, fyid_d, iyid_q, iyid_d, pyid_q, pyid_d, oyid_q, oyid_d;
  logic             load, cfg_bad;

  assign cfg_bad = (cfg_kh == '0) || (32'(cfg_kh) > H_U) ||
                   (cfg_e == '0)  || (32'(cfg_e) > W_U)  ||
                   (cfg_linear && (32'(cfg_t) > W_U));

  // k, s, j mod e and kh*(j div e) are walked incrementally so no divider is needed.
  always_comb begin
    state_d   = state_q;
    linear_d  = linear_q;
    kh_d      = kh_q;
    e_d       = e_q;
    t_d       = t_q;
    row_d     = row_q;
    col_d     = col_q;
    k_d       = k_q;
    s_d       = s_q;
    jm_d      = jm_q;
    fx_d      = fx_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            linear_d = cfg_linear;
            kh_d     = cfg_kh;
            e_d      = cfg_e;
            t_d      = cfg_t;
            row_d    = '0;
            col_d    = '0;
            k_d      = '0;
            s_d      = '0;
            jm_d     = '0;
            fx_d     = '0;
            valid_d  = 1'b1;
            load     = 1'b1;
            state_d  = EMIT;
          end
        end
      end
      EMIT: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (valid_q && out_if.out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            load = 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              jm_d  = '0;
              fx_d  = '0;
              row_d = row_q + ROW_W'(1);
              if (32'(k_q) + 32'd1 == 32'(kh_q)) begin
                k_d = '0;
                s_d = s_q + ROW_W'(1);
              end else begin
                k_d = k_q + ROW_W'(1);
              end
            end else begin
              col_d = col_q + COL_W'(1);
              if (32'(jm_q) + 32'd1 == 32'(e_q)) begin
                jm_d = '0;
                fx_d = fx_q + FX_W'(kh_q);
              end else begin
                jm_d = jm_q + COL_W'(1);
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == EMIT);
  end

  // Tags are recomputed only when a new PE is presented, so they hold through stalls.
  always_comb begin
    last_d = last_q;
    fxid_d = fxid_q;
    fyid_d = fyid_q;
    ixid_d = ixid_q;
    iyid_d = iyid_q;
    pxid_d = pxid_q;
    pyid_d = pyid_q;
    oxid_d = oxid_q;
    oyid_d = oyid_q;
    if (load) begin
      last_d = (row_d == LAST_ROW) && (col_d == LAST_COL);
      fxid_d = '1;
      fyid_d = '1;
      ixid_d = '1;
      iyid_d = '1;
      pxid_d = '1;
      pyid_d = '1;
      oxid_d = '1;
      oyid_d = '1;
      if (!linear_d) begin
        // Row belongs to a complete set of kh rows: s*kh + kh <= ARR_H.
        if (32'(row_d) - 32'(k_d) + 32'(kh_d) <= H_U) begin
          fxid_d = XID_W'(32'(k_d) + 32'(fx_d));
          fyid_d = YID_W'(s_d);
          ixid_d = XID_W'(32'(k_d) + 32'(jm_d));
          iyid_d = YID_W'(s_d);
          if (k_d == '0) begin
            pxid_d = XID_W'(col_d);
            pyid_d = YID_W'(s_d);
          end
          if (32'(k_d) + 32'd1 == 32'(kh_d)) begin
            oxid_d = XID_W'(col_d);
            oyid_d = YID_W'(s_d);
          end
        end
      end else begin
        fyid_d = YID_W'(row_d);
        iyid_d = YID_W'(row_d);
        if (32'(col_d) < 32'(t_d)) begin
          fxid_d = XID_W'(col_d);
          ixid_d = '0;
          if (row_d == '0) begin
            pxid_d = XID_W'(col_d);
            pyid_d = '0;
          end
          if (row_d == LAST_ROW) begin
            oxid_d = XID_W'(col_d);
            oyid_d = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      linear_q  <= 1'b0;
      kh_q      <= '0;
      e_q       <= '0;
      t_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      k_q       <= '0;
      s_q       <= '0;
      jm_q      <= '0;
      fx_q      <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      fxid_q    <= '0;
      fyid_q    <= '0;
      ixid_q    <= '0;
      iyid_q    <= '0;
      pxid_q    <= '0;
      pyid_q    <= '0;
      oxid_q    <= '0;
      oyid_q    <= '0;
    end else begin
      state_q   <= state_d;
      linear_q  <= linear_d;
      kh_q      <= kh_d;
      e_q       <= e_d;
      t_q       <= t_d;
      row_q     <= row_d;
      col_q     <= col_d;
      k_q       <= k_d;
      s_q       <= s_d;
      jm_q      <= jm_d;
      fx_q      <= fx_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      fxid_q    <= fxid_d;
      fyid_q    <= fyid_d;
      ixid_q    <= ixid_d;
      iyid_q    <= iyid_d;
      pxid_q    <= pxid_d;
      pyid_q    <= pyid_d;
      oxid_q    <= oxid_d;
      oyid_q    <= oyid_d;
    end
  end

  assign out_if.out_valid  = valid_q;
  assign out_if.out_row    = row_q;
  assign out_if.out_col    = col_q;
  assign out_if.out_last   = last_q;
  assign out_if.filter_xid = fxid_q;
  assign out_if.filter_yid = fyid_q;
  assign out_if.ifmap_xid  = ixid_q;
  assign out_if.ifmap_yid  = iyid_q;
  assign out_if.ipsum_xid  = pxid_q;
  assign out_if.ipsum_yid  = pyid_q;
  assign out_if.opsum_xid  = oxid_q;
  assign out_if.opsum_yid  = oyid_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign cfg_err           = cfg_err_q;
endmodule
`default_nettype wire

// File: tb/tb_mcast_id_seq_gen.sv
`default_nettype none
// tb_mcast_id_seq_gen: scoreboard bench with a divide/modulo reference model of the tag rules.
module tb_mcast_id_seq_gen;
  localparam int H = 6, W = 8, XW = 5, YW = 3;
  localparam int RW = 3, CW = 3, KW = 3, EW = 4;

  typedef struct packed {
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [XW-1:0] fx;
    logic [YW-1:0] fy;
    logic [XW-1:0] ix;
    logic [YW-1:0] iy;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [XW-1:0] ox;
    logic [YW-1:0] oy;
    logic          last;
  } tagset_t;

  logic clk, rst_n, start, abort, cfg_linear;
  logic [KW-1:0] cfg_kh;
  logic [EW-1:0] cfg_e, cfg_t;
  logic busy, done, cfg_err;

  mcast_id_seq_gen_if #(.ARR_H(H), .ARR_W(W), .XID_W(XW), .YID_W(YW)) ifc ();

  mcast_id_seq_gen #(.ARR_H(H), .ARR_W(W), .XID_W(XW), .YID_W(YW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_linear(cfg_linear), .cfg_kh(cfg_kh), .cfg_e(cfg_e), .cfg_t(cfg_t),
    .out_if(ifc), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  int total = 0, passed = 0, cyc = 0, xfers = 0, last_xfer_cyc = -10, rdy_pct = 100;
  tagset_t sb[$];
  tagset_t seen [H][W];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      ifc.out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Reference model: the tag rules written with plain div/mod arithmetic.
  function automatic tagset_t model(input int i, input int j, input bit lin, input int kh,
                                    input int e, input int t);
    tagset_t r;
    r = '1;
    r.row = RW'(i);
    r.col = CW'(j);
    r.last = (i == H-1) && (j == W-1);
    if (!lin) begin
      int k, s;
      k = i % kh;
      s = i / kh;
      if (s < H / kh) begin
        r.fx = XW'(k + kh * (j / e));
        r.fy = YW'(s);
        r.ix = XW'(k + j % e);
        r.iy = YW'(s);
        if (k == 0) begin r.px = XW'(j); r.py = YW'(s); end
        if (k == kh-1) begin r.ox = XW'(j); r.oy = YW'(s); end
      end
    end else begin
      r.fy = YW'(i);
      r.iy = YW'(i);
      if (j < t) begin
        r.fx = XW'(j);
        r.ix = '0;
        if (i == 0) begin r.px = XW'(j); r.py = '0; end
        if (i == H-1) begin r.ox = XW'(j); r.oy = '0; end
      end
    end
    return r;
  endfunction

  function automatic tagset_t dut_tags();
    tagset_t r;
    r.row = ifc.out_row;     r.col = ifc.out_col;
    r.fx = ifc.filter_xid;   r.fy = ifc.filter_yid;
    r.ix = ifc.ifmap_xid;    r.iy = ifc.ifmap_yid;
    r.px = ifc.ipsum_xid;    r.py = ifc.ipsum_yid;
    r.ox = ifc.opsum_xid;    r.oy = ifc.opsum_yid;
    r.last = ifc.out_last;
    return r;
  endfunction

  function automatic logic [31:0] tags_of(input tagset_t r);
    return {r.fx, r.fy, r.ix, r.iy, r.px, r.py, r.ox, r.oy};
  endfunction

  // Monitor: whenever a tag set is presented it must match the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (ifc.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'(dut_tags()), 64'd0);
      end else begin
        chk("tagset", 64'(dut_tags()), 64'(sb[0]));
        if (ifc.out_ready) begin
          if (int'(ifc.out_row) < H && int'(ifc.out_col) < W)
            seen[ifc.out_row][ifc.out_col] = dut_tags();
          void'(sb.pop_front());
          xfers++;
          last_xfer_cyc = cyc;
        end
      end
    end
  end

  task automatic start_cfg(input bit lin, input int kh, input int e, input int t, input bit push);
    @(posedge clk);
    #1;
    start = 1'b1;
    cfg_linear = lin;
    cfg_kh = KW'(kh);
    cfg_e = EW'(e);
    cfg_t = EW'(t);
    if (push) begin
      xfers = 0;
      for (int i = 0; i < H; i++)
        for (int j = 0; j < W; j++)
          sb.push_back(model(i, j, lin, kh, e, t));
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    if (n >= 3000) begin
      chk({name, "_done_timeout"}, 64'd0, 64'd1);
      sb.delete();
    end else begin
      chk({name, "_done_timing"}, 64'(cyc), 64'(last_xfer_cyc + 1));
      chk({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
      chk({name, "_valid_low_at_done"}, 64'(ifc.out_valid), 64'd0);
      @(negedge clk);
      chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
    end
  endtask

  task automatic wait_xfers(input int target);
    int n;
    n = 0;
    while (xfers < target && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) chk("xfer_wait_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int kh, e, t;
    bit lin, saw_done;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_linear = 1'b0; cfg_kh = '0; cfg_e = '0; cfg_t = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tags", 64'(dut_tags()), 64'd0);
    chk("reset_flags", 64'({ifc.out_valid, busy, done, cfg_err}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Conv 6x8, kh=3, e=4, always ready.
    start_cfg(1'b0, 3, 4, 0, 1'b1);
    wait_done("conv34");
    chk("conv34_xfers", 64'(xfers), 64'd48);
    chk("conv34_pe00", 64'(tags_of(seen[0][0])),
        64'({5'd0, 3'd0, 5'd0, 3'd0, 5'd0, 3'd0, 5'd31, 3'd7}));
    chk("conv34_pe25", 64'(tags_of(seen[2][5])),
        64'({5'd5, 3'd0, 5'd3, 3'd0, 5'd31, 3'd7, 5'd5, 3'd0}));
    chk("conv34_pe47", 64'(tags_of(seen[4][7])),
        64'({5'd4, 3'd1, 5'd4, 3'd1, 5'd31, 3'd7, 5'd31, 3'd7}));
    chk("conv34_last_flag", 64'(seen[5][7].last), 64'd1);

    // Linear t=5 under backpressure.
    rdy_pct = 50;
    start_cfg(1'b1, 3, 4, 5, 1'b1);
    wait_done("lin5");
    chk("lin5_pe03", 64'({seen[0][3].fx, seen[0][3].fy, seen[0][3].ix, seen[0][3].iy,
                         seen[0][3].px, seen[0][3].py}),
        64'({5'd3, 3'd0, 5'd0, 3'd0, 5'd3, 3'd0}));
    chk("lin5_pe52_opsum", 64'({seen[5][2].ox, seen[5][2].oy}), 64'({5'd2, 3'd0}));
    chk("lin5_pe56", 64'({seen[5][6].fx, seen[5][6].ix, seen[5][6].ox, seen[5][6].oy}),
        64'({5'd31, 5'd31, 5'd31, 3'd7}));

    // Conv kh=4, e=8: incomplete row set.
    start_cfg(1'b0, 4, 8, 0, 1'b1);
    wait_done("conv48");
    chk("conv48_row4", 64'(tags_of(seen[4][0])), 64'(32'hFFFF_FFFF));
    chk("conv48_row5", 64'(tags_of(seen[5][7])), 64'(32'hFFFF_FFFF));
    chk("conv48_pe36", 64'({seen[3][6].ox, seen[3][6].oy, seen[3][6].fx, seen[3][6].ix}),
        64'({5'd6, 3'd0, 5'd3, 5'd9}));

    // Random configurations and ready patterns.
    for (int r = 0; r < 6; r++) begin
      lin = 1'($urandom_range(1));
      do begin
        kh = $urandom_range(H, 1);
        e = $urandom_range(W, 1);
      end while (!lin && (kh * (1 + (W-1) / e) > 31));
      t = $urandom_range(W, 0);
      rdy_pct = $urandom_range(90, 30);
      start_cfg(lin, kh, e, t, 1'b1);
      wait_done("rand");
    end
    rdy_pct = 100;

    // Invalid configurations.
    for (int r = 0; r < 2; r++) begin
      start_cfg(1'b0, (r == 0) ? 3 : 7, (r == 0) ? 0 : 4, 0, 1'b0);
      @(negedge clk);
      chk("cfg_err_pulse", 64'({cfg_err, ifc.out_valid, busy}), 64'({1'b1, 1'b0, 1'b0}));
      @(negedge clk);
      chk("cfg_err_after", 64'({cfg_err, ifc.out_valid, busy}), 64'd0);
    end

    // start and abort together in IDLE: abort wins.
    @(posedge clk);
    #1 start = 1'b1; abort = 1'b1; cfg_kh = 3'd3; cfg_e = 4'd4; cfg_linear = 1'b0;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", 64'({ifc.out_valid, busy}), 64'd0);

    // Abort after 10 transfers.
    start_cfg(1'b0, 3, 4, 0, 1'b1);
    wait_xfers(10);
    rdy_pct = 0;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_valid_low", 64'({ifc.out_valid, busy}), 64'd0);
    chk("abort_xfers", 64'(xfers), 64'd10);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    sb.delete();
    rdy_pct = 100;

    // Restart from PE(0,0); a second start mid-run must be ignored.
    start_cfg(1'b0, 3, 4, 0, 1'b1);
    repeat (3) @(posedge clk);
    start_cfg(1'b1, 2, 3, 2, 1'b0);
    wait_done("restart");

    // Async reset at transfer 20.
    rdy_pct = 60;
    start_cfg(1'b1, 2, 2, 6, 1'b1);
    wait_xfers(20);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_tags", 64'(dut_tags()), 64'd0);
    chk("midrun_reset_flags", 64'({ifc.out_valid, busy, done, cfg_err}), 64'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || ifc.out_valid) saw_done = 1'b1;
    end
    chk("reset_no_done", 64'(saw_done), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mcast_id_seq_gen.md
Name: mcast_id_seq_gen

Overview:
- Parametrised successor to the fixed 6x8 multicast ID generator.
- Serially computes the filter, ifmap, ipsum and opsum XID/YID tags for every PE of an ARR_H x ARR_W array, one PE per accepted transfer.
- Streams the tags over a valid/ready interface to the PE-array config loader, with runtime conv/linear mode, kernel height and column grouping.
- Replaces the flat 48-entry output arrays with a scalable stream and adds config checking, abort and backpressure.

Parameters:
- ARR_H, 6, PE rows (>=1).
- ARR_W, 8, PE columns (>=1).
- XID_W, 5, X-tag width; all-ones = disabled.
- YID_W, 3, Y-tag width; all-ones = disabled.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- start  in  1  pulse; latch cfg_* and begin generation.
- abort  in  1  synchronous cancel of the current generation.
- cfg_linear  in  1  0 = conv mode, 1 = linear mode.
- cfg_kh  in  clog2(ARR_H+1)  kernel height (rows per set).
- cfg_e  in  clog2(ARR_W+1)  columns per ifmap group.
- cfg_t  in  clog2(ARR_W+1)  active columns in linear mode.
- out_valid  out  1  tag set valid.
- out_ready  in  1  consumer ready.
- out_row  out  clog2(ARR_H)  PE row i.
- out_col  out  clog2(ARR_W)  PE column j.
- filter_xid / ifmap_xid / ipsum_xid / opsum_xid  out  XID_W each  X tags.
- filter_yid / ifmap_yid / ipsum_yid / opsum_yid  out  YID_W each  Y tags.
- out_last  out  1  current PE is (ARR_H-1, ARR_W-1).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the final transfer.
- cfg_err  out  1  one-cycle pulse when start carries an invalid config.

Behaviour:
- Reset: state IDLE; all outputs 0, including every tag, out_row/out_col, out_valid, out_last, busy, done and cfg_err.
- FSM states: IDLE, EMIT.
- IDLE + start, config valid: latch cfg_*, i=j=0, go to EMIT. out_valid rises the next cycle.
- IDLE + start, config invalid (kh==0, kh>ARR_H, e==0, e>ARR_W, or linear with t>ARR_W): cfg_err pulses the next cycle; state stays IDLE; nothing is latched.
- EMIT, scan order: row-major with column innermost. Advance only on out_valid && out_ready. All outputs hold stable while out_valid && !out_ready.
- EMIT, completion: on the transfer with out_last=1, go to IDLE; done pulses the following cycle and out_valid drops.
- start during EMIT is ignored; the latched config stays unchanged.
- abort in EMIT: go to IDLE next cycle, out_valid drops, no done. abort in IDLE has no effect. abort and start in the same cycle in IDLE: abort wins.
- Conv-mode definitions: k = i mod kh; s = i div kh; S = ARR_H div kh. Rows with s >= S: all tags all-ones.
- Conv-mode tags for rows with s < S:
  - filter_xid = k + kh*(j div e); filter_yid = s.
  - ifmap_xid = k + (j mod e); ifmap_yid = s.
  - ipsum: k==0 gives (xid=j, yid=s); otherwise all-ones.
  - opsum: k==kh-1 gives (xid=j, yid=s); otherwise all-ones.
- Linear mode, j<t:
  - filter (xid=j, yid=i); ifmap (xid=0, yid=i).
  - ipsum (j, 0) on row 0 only; opsum (j, 0) on row ARR_H-1 only.
  - Every other tag is all-ones.
- Linear mode, j>=t: filter_xid and ifmap_xid are all-ones; ipsum and opsum tags are all-ones.
- Arithmetic:
  - No dividers. k, s, (j mod e) and kh*(j div e) are incremental counters/accumulators updated per transfer and reset at row and column wrap.
  - Tags are truncated to XID_W/YID_W.
  - A config whose valid tag evaluates to all-ones is unsupported and not checked.
- Async reset mid-EMIT: returns to reset values immediately; no done.

Test Plan:
- Conv, ARR 6x8, kh=3, e=4 -> 48 transfers.
  - PE(0,0): filter(0,0), ifmap(0,0), ipsum(0,0), opsum(31,7).
  - PE(2,5): filter(5,0), ifmap(3,0), ipsum(31,7), opsum(5,0).
  - PE(4,7): filter(4,1), ifmap(4,1), ipsum and opsum all-ones.
  - out_last on the 48th transfer; done the next cycle.
- Linear, t=5:
  - PE(0,3): filter(3,0), ifmap(0,0), ipsum(3,0).
  - PE(5,2): opsum(2,0).
  - PE(5,6): filter_xid=31, ifmap_xid=31, opsum(31,7).
- Conv, kh=4, e=8: rows 4-5 all tags all-ones; PE(3,6) gives opsum(6,0), filter_xid=3, ifmap_xid=9.
- Backpressure: out_ready random (about 50%) -> each (row,col) seen exactly once in order; outputs unchanged during stalls; done after the last transfer.
- start with e=0, then with kh=7 -> cfg_err pulse each time; out_valid never rises; busy stays 0.
- Abort after 10 transfers, then restart -> out_valid low next cycle, no done; restart begins at PE(0,0). A second start mid-run is ignored. rst_n low at transfer 20 -> all outputs 0 immediately.
